// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: FSM state encoding,
// line levels and a width helper for counters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last
// count. Held at zero while clear is high so each frame starts phase-aligned.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign bit_done = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB-first, optional even
// parity (enabled by defining UART_TX_PARITY_EN), one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             data_out,
  output logic             busy
);

  localparam int IW = clog2(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [IW-1:0]    bit_idx, bit_idx_n;
  logic             data_out_n, busy_n;
  logic             bit_done;
`ifdef UART_TX_PARITY_EN
  logic             parity, parity_n;
`endif

  // Timer is held in reset while idle, so the first bit period begins
  // exactly at the accepting edge.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      data_out <= IDLE_LVL;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      data_out <= data_out_n;
      busy     <= busy_n;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    data_out_n = data_out;
    busy_n     = busy;
`ifdef UART_TX_PARITY_EN
    parity_n   = parity;
`endif
    unique case (state)
      IDLE: begin
        data_out_n = IDLE_LVL;
        busy_n     = 1'b0;
        if (start) begin
          shreg_n    = data;
          bit_idx_n  = '0;
          state_n    = START;
          data_out_n = START_LVL;
          busy_n     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_n   = ^data;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_n    = DATA;
          data_out_n = shreg[0];
          shreg_n    = {1'b0, shreg[WIDTH-1:1]};
          bit_idx_n  = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == IW'(WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n    = PARITY;
            data_out_n = parity;
`else
            state_n    = STOP;
            data_out_n = IDLE_LVL;
`endif
          end else begin
            data_out_n = shreg[0];
            shreg_n    = {1'b0, shreg[WIDTH-1:1]};
            bit_idx_n  = bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_n    = STOP;
          data_out_n = IDLE_LVL;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_n    = IDLE;
          data_out_n = IDLE_LVL;
          busy_n     = 1'b0;
        end
      end
      default: begin
        state_n    = IDLE;
        data_out_n = IDLE_LVL;
        busy_n     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized frames for uart_tx, checked cycle-by-cycle against
// a per-bit waveform model built from the frame format.
module tb_uart_tx;

  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int FRAME = (2 + W + PB) * CPB;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data;
  logic         data_out;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [0:0] exp_q[$];

  uart_tx #(
    .WIDTH       (W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data    (data),
    .data_out(data_out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Expected line level for every clock of one frame.
  function automatic void push_frame(input logic [W-1:0] w);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(w[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^w);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < CPB; c++) exp_q.push_back(bits[i]);
  endfunction

  task automatic check_cycles(input int n);
    logic [0:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("model_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("frame_line", 32'(data_out), 32'(e));
        chk("frame_busy", 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_line", 32'(data_out), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    data  = w;
    start = 1'b1;
    push_frame(w);
    check_cycles(1);
    start = 1'b0;
    check_cycles(FRAME - 1);
  endtask

  initial begin
    logic [W-1:0] w;
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;

    // Reset and quiet idle line
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_line", 32'(data_out), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    check_idle(20);

    // Single frame 0x4C, busy exactly one frame long
    send(8'h4C);
    check_idle(3);

    // Mid-frame start pulse and data change are ignored
    data  = 8'hA5;
    start = 1'b1;
    push_frame(8'hA5);
    check_cycles(1);
    start = 1'b0;
    check_cycles(CPB + 3 * CPB);
    start = 1'b1;
    data  = 8'hFF;
    check_cycles(1);
    start = 1'b0;
    check_cycles(FRAME - 2 - 4 * CPB);
    check_idle(FRAME + 2);

    // start held high: back-to-back frames with one idle cycle between
    data  = 8'h01;
    start = 1'b1;
    push_frame(8'h01);
    check_cycles(1);
    data = 8'h80;
    check_cycles(FRAME - 1);
    check_idle(1);
    push_frame(8'h80);
    check_cycles(1);
    start = 1'b0;
    check_cycles(FRAME - 1);
    check_idle(3);

    // Reset during data bit 5 aborts the frame
    w = W'($urandom_range(0, 255));
    data  = w;
    start = 1'b1;
    push_frame(w);
    check_cycles(1);
    start = 1'b0;
    check_cycles(CPB + 5 * CPB);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_line", 32'(data_out), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    check_idle(3);
    send(8'h3C);
    check_idle(2);

    // Parity-relevant word
    send(8'h07);
    check_idle(2);

    // Random words with random idle gaps
    for (int k = 0; k < 8; k++) begin
      send(W'($urandom_range(0, 255)));
      check_idle($urandom_range(1, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
